// File: rtl/xlib_fifo_burst_pkg.sv
// xlib_fifo_burst_pkg: types shared by the burst FIFO files
package xlib_fifo_burst_pkg;
  typedef enum logic {IDLE, FLUSH} fsm_e;
endpackage

// File: rtl/xlib_fifo_outreg.sv
// xlib_fifo_outreg: head-of-queue output register with array/bypass load select
module xlib_fifo_outreg
  import xlib_fifo_burst_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          init_i,
  input  logic          wr_ok_i,
  input  logic          rd_ok_i,
  input  logic          arr_ne_i,
  input  logic [DW-1:0] head_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          push_o,
  output logic          pop_o
);
  logic [DW-1:0] q_q, q_d;
  logic          v_q, v_d, byp;
  assign byp    = wr_ok_i && (!v_q || (rd_ok_i && !arr_ne_i));
  assign pop_o  = rd_ok_i && arr_ne_i;
  assign push_o = wr_ok_i && !byp;
  assign q_d    = init_i ? '0 : pop_o ? head_i : byp ? d_i : q_q;
  assign v_d    = !init_i && (pop_o || byp || (v_q && !rd_ok_i));
  assign q_o    = q_q;
  // head register: refills from the array, else takes the incoming word directly
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      q_q <= '0;
      v_q <= 1'b0;
    end else begin
      q_q <= q_d;
      v_q <= v_d;
    end
endmodule

// File: rtl/xlib_fifo_burst.sv
// xlib_fifo_burst: single-clock FIFO with optional output register, level flags and burst-ready/flush logic
module xlib_fifo_burst
  import xlib_fifo_burst_pkg::*;
#(
  parameter int FW      = 4,
  parameter int DW      = 32,
  parameter int REG_OUT = 0,
  parameter int AF_LVL  = 2**FW-2,
  parameter int AE_LVL  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          we,
  input  logic [DW-1:0] d,
  input  logic          re,
  output logic [DW-1:0] q,
  output logic          ne,
  output logic          nf,
  output logic [FW:0]   lv,
  output logic          af,
  output logic          ae,
  input  logic [FW:0]   burst_len,
  input  logic          flush,
  output logic          burst_rdy,
  output logic          ovf,
  output logic          udf
);
  localparam logic [FW:0] FULL  = (FW+1)'(2**FW);
  localparam logic [FW:0] AF_TH = (FW+1)'(AF_LVL);
  localparam logic [FW:0] AE_TH = (FW+1)'(AE_LVL);
  logic [DW-1:0] mem [2**FW];
  logic [FW:0]   wptr_q, rptr_q, lv_q, lv_d;
  logic          ovf_q, udf_q, wr_ok, rd_ok, push, pop;
  logic [DW-1:0] head;
  fsm_e          st_q;
  assign lv        = lv_q;
  assign ne        = lv_q != '0;
  assign nf        = lv_q != FULL;
  assign af        = lv_q >= AF_TH;
  assign ae        = lv_q <= AE_TH;
  assign burst_rdy = (burst_len != '0 && lv_q >= burst_len) || (st_q == FLUSH && ne);
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign rd_ok     = re && ne;
  assign wr_ok     = we && (nf || rd_ok);
  assign lv_d      = lv_q + (FW+1)'(wr_ok) - (FW+1)'(rd_ok);
  assign head      = mem[rptr_q[FW-1:0]];
  if (REG_OUT != 0) begin : g_reg
    xlib_fifo_outreg #(.DW(DW)) u_outreg (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .init_i  (init),
      .wr_ok_i (wr_ok),
      .rd_ok_i (rd_ok),
      .arr_ne_i(wptr_q != rptr_q),
      .head_i  (head),
      .d_i     (d),
      .q_o     (q),
      .push_o  (push),
      .pop_o   (pop)
    );
  end else begin : g_comb
    assign q    = head;
    assign push = wr_ok;
    assign pop  = rd_ok;
  end
  // storage array, deliberately left untouched by reset and init
  always_ff @(posedge clk)
    if (push && !init) mem[wptr_q[FW-1:0]] <= d;
  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lv_q   <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (init) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lv_q   <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_q + (FW+1)'(push);
      rptr_q <= rptr_q + (FW+1)'(pop);
      lv_q   <= lv_d;
      ovf_q  <= ovf_q | (we & ~wr_ok);
      udf_q  <= udf_q | (re & ~rd_ok);
    end
  // flush tracker: entered on a flush pulse, held until the FIFO drains
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= IDLE;
    else if (init || lv_d == '0) st_q <= IDLE;
    else if (flush) st_q <= FLUSH;
endmodule

// File: tb/tb_xlib_fifo_burst.sv
// tb_xlib_fifo_burst: queue-model checked bench over three FIFO configurations
module tb_xlib_fifo_burst;
  logic        clk, rst_n, init, we, re, flush;
  logic [31:0] d;
  logic [4:0]  bl;
  int          nv = 0;
  int          nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    nv++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, g, $time, a, e);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int FW  = (g == 2) ? 4 : 2;
    localparam int RO  = (g == 0) ? 0 : 1;
    localparam int CAP = 2**FW;
    logic [31:0] q;
    logic [FW:0] lv;
    logic        ne, nf, af, ae, brdy, ovf, udf;
    logic [31:0] mq[$];
    bit          mfl, movf, mudf, rok, wok;
    int          n;
    logic [FW:0] blt;

    xlib_fifo_burst #(.FW(FW), .DW(32), .REG_OUT(RO)) u_dut (
      .clk(clk), .rst_n(rst_n), .init(init), .we(we), .d(d), .re(re), .q(q),
      .ne(ne), .nf(nf), .lv(lv), .af(af), .ae(ae), .burst_len(bl[FW:0]),
      .flush(flush), .burst_rdy(brdy), .ovf(ovf), .udf(udf)
    );

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || init) begin
        mq.delete();
        mfl = 0;
        movf = 0;
        mudf = 0;
      end else begin
        rok = re && mq.size() > 0;
        wok = we && (mq.size() < CAP || rok);
        if (we && !wok) movf = 1;
        if (re && !rok) mudf = 1;
        if (rok) void'(mq.pop_front());
        if (wok) mq.push_back(d);
        mfl = (mq.size() == 0) ? 0 : (flush ? 1 : mfl);
      end
    end

    always @(negedge clk) begin
      n   = mq.size();
      blt = bl[FW:0];
      chk("lv", g, 32'(lv), n);
      chk("ne", g, 32'(ne), 32'(n > 0));
      chk("nf", g, 32'(nf), 32'(n < CAP));
      chk("af", g, 32'(af), 32'(n >= CAP - 2));
      chk("ae", g, 32'(ae), 32'(n <= 2));
      chk("ovf", g, 32'(ovf), 32'(movf));
      chk("udf", g, 32'(udf), 32'(mudf));
      chk("burst_rdy", g, 32'(brdy), 32'((blt != 0 && n >= int'(blt)) || (mfl && n > 0)));
      if (n > 0) chk("q", g, q, mq[0]);
    end
  end

  task automatic step(input bit w, input logic [31:0] wd, input bit r, input bit fl = 0, input bit in = 0);
    we = w;
    d = wd;
    re = r;
    flush = fl;
    init = in;
    @(posedge clk);
    #1;
    we = 0;
    re = 0;
    flush = 0;
    init = 0;
  endtask

  initial begin
    rst_n = 0; init = 0; we = 0; re = 0; flush = 0; d = 0; bl = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 1, g_u[1].q, 0);
    chk("rst_lv", 0, 32'(g_u[0].lv), 0);
    chk("rst_nf", 2, 32'(g_u[2].nf), 1);
    chk("rst_ae", 0, 32'(g_u[0].ae), 1);
    rst_n = 1;
    for (int i = 0; i < 4; i++) step(1, 32'h11 + i, 0);
    chk("fill_lv", 0, 32'(g_u[0].lv), 4);
    chk("fill_nf", 1, 32'(g_u[1].nf), 0);
    chk("fill_af", 0, 32'(g_u[0].af), 1);
    chk("fill_q", 1, g_u[1].q, 32'h11);
    step(1, 32'h55, 0);
    chk("ovf_flag", 0, 32'(g_u[0].ovf), 1);
    chk("ovf_lv", 1, 32'(g_u[1].lv), 4);
    chk("ovf_fw4", 2, 32'(g_u[2].ovf), 0);
    step(1, 32'h66, 1);
    chk("sim_full_lv", 1, 32'(g_u[1].lv), 4);
    chk("sim_full_q0", 0, g_u[0].q, 32'h12);
    chk("sim_full_q1", 1, g_u[1].q, 32'h12);
    step(0, 0, 1);
    chk("drain_q", 0, g_u[0].q, 32'h13);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("drain_q", 1, g_u[1].q, 32'h66);
    step(0, 0, 1);
    chk("drain_ne", 0, 32'(g_u[0].ne), 0);
    chk("drain_ae", 1, 32'(g_u[1].ae), 1);
    step(0, 0, 1);
    chk("udf_flag", 1, 32'(g_u[1].udf), 1);
    chk("udf_fw4", 2, 32'(g_u[2].udf), 0);
    step(0, 0, 0, 0, 1);
    chk("init_ovf", 0, 32'(g_u[0].ovf), 0);
    chk("init_udf", 1, 32'(g_u[1].udf), 0);
    step(1, 32'h77, 1);
    chk("sim_empty_lv", 0, 32'(g_u[0].lv), 1);
    chk("sim_empty_udf", 1, 32'(g_u[1].udf), 1);
    chk("sim_empty_q0", 0, g_u[0].q, 32'h77);
    chk("sim_empty_q1", 1, g_u[1].q, 32'h77);
    step(0, 0, 0, 0, 1);
    bl = 8;
    for (int i = 0; i < 7; i++) step(1, 32'hA0 + i, 0);
    chk("burst7", 2, 32'(g_u[2].brdy), 0);
    step(1, 32'hA7, 0);
    chk("burst8", 2, 32'(g_u[2].brdy), 1);
    bl = 0;
    #1;
    chk("burst_len0", 2, 32'(g_u[2].brdy), 0);
    step(0, 0, 0, 0, 1);
    bl = 8;
    for (int i = 0; i < 3; i++) step(1, 32'hB0 + i, 0);
    chk("pre_flush", 2, 32'(g_u[2].brdy), 0);
    step(0, 0, 0, 1);
    chk("flush_rdy", 2, 32'(g_u[2].brdy), 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("flush_mid", 2, 32'(g_u[2].brdy), 1);
    step(0, 0, 1);
    chk("flush_done", 2, 32'(g_u[2].brdy), 0);
    step(0, 0, 0, 1);
    step(1, 32'hC0, 0);
    chk("flush_empty", 2, 32'(g_u[2].brdy), 0);
    step(0, 0, 0, 0, 1);
    bl = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rst_n = 0;
        #1;
        chk("arst_lv", 2, 32'(g_u[2].lv), 0);
        chk("arst_ne", 1, 32'(g_u[1].ne), 0);
        chk("arst_ovf", 0, 32'(g_u[0].ovf), 0);
        chk("arst_q", 1, g_u[1].q, 0);
        chk("arst_q", 2, g_u[2].q, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
      end
      step($urandom_range(0, 3) != 0, $urandom, (i < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) != 0));
    end
    step(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
